// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider / tick generator with per-channel
// divisor staging. Optional global phase restart under `CLKDIV_SYNC_EN`.
module clk_divider_prog #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_AW       = 2,
  parameter int unsigned DEFAULT_DIV = 6000000
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_start,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_AW-1:0]  cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [WIDTH-1:0] DIV_RST = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

  logic [NUM_CH-1:0][WIDTH-1:0] cnt, cnt_n;
  logic [NUM_CH-1:0][WIDTH-1:0] div_act, div_act_n;
  logic [NUM_CH-1:0][WIDTH-1:0] div_pend, div_pend_n;
  logic [NUM_CH-1:0]            pend_n, clk_n, tick_n;
  logic                         restart;
  logic                         cfg_fire;

  // Divisors below 2 cannot form a high and a low phase.
  function automatic logic [WIDTH-1:0] sat_div(input logic [WIDTH-1:0] d);
    return (d < WIDTH'(2)) ? WIDTH'(2) : d;
  endfunction

`ifdef CLKDIV_SYNC_EN
  assign restart = sync_start;
`else
  assign restart = 1'b0;
`endif

  // One staging slot per channel; out-of-range channels always accept and drop.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_AW'(i) && pending[i]) cfg_ready = 1'b0;
    end
  end

  assign cfg_fire = cfg_valid & cfg_ready;

  always_comb begin
    cnt_n      = cnt;
    div_act_n  = div_act;
    div_pend_n = div_pend;
    pend_n     = pending;
    clk_n      = '0;
    tick_n     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Period boundary (wrap, disable or restart) is the only point a new divisor lands.
      if (restart || !en[i] || (cnt[i] == div_act[i] - WIDTH'(1))) begin
        cnt_n[i] = '0;
        if (pending[i]) begin
          div_act_n[i] = div_pend[i];
          pend_n[i]    = 1'b0;
        end
      end else begin
        cnt_n[i] = cnt[i] + WIDTH'(1);
      end
      if (cfg_fire && (cfg_ch == CH_AW'(i))) begin
        div_pend_n[i] = sat_div(cfg_div);
        pend_n[i]     = 1'b1;
      end
      // Outputs decoded from next-state count so they register glitch-free and in phase.
      if (!restart && en[i]) begin
        clk_n[i]  = (cnt_n[i] >= (div_act_n[i] >> 1));
        tick_n[i] = (cnt_n[i] == div_act_n[i] - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        div_act[i]  <= DIV_RST;
        div_pend[i] <= DIV_RST;
      end
      pending <= '0;
      clk_out <= '0;
      tick    <= '0;
    end else begin
      cnt      <= cnt_n;
      div_act  <= div_act_n;
      div_pend <= div_pend_n;
      pending  <= pend_n;
      clk_out  <= clk_n;
      tick     <= tick_n;
    end
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: a period-waveform reference model feeds
// expected outputs into queues that independent monitors drain and compare.
module tb_clk_divider_prog;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_AW  = 2;
  localparam int unsigned DEF    = 4;

  logic              clk_in;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_AW-1:0]  cfg_ch;
  logic [WIDTH-1:0]  cfg_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;
`ifdef CLKDIV_SYNC_EN
  logic              sync_start;
`endif

  clk_divider_prog #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_AW(CH_AW), .DEFAULT_DIV(DEF)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .en(en),
`ifdef CLKDIV_SYNC_EN
    .sync_start(sync_start),
`endif
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .clk_out(clk_out),
    .tick(tick),
    .pending(pending)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each channel holds the remaining (clk,tick) samples of its current period.
  logic [1:0]        left [NUM_CH][$];
  int unsigned       dact [NUM_CH];
  int unsigned       dpend [NUM_CH];
  bit [NUM_CH-1:0]   pm;
  bit                known = 1'b0;

  logic [3*NUM_CH-1:0] out_q[$];
  logic                rdy_q[$];

  function automatic int unsigned sat(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction

  // Samples 1..d-1 of a period: floor(d/2) low cycles first, tick on the last.
  function automatic void load(input int ch, input int unsigned d);
    left[ch].delete();
    for (int unsigned k = 1; k < d; k++)
      left[ch].push_back({1'(k >= d / 2), 1'(k == d - 1)});
  endfunction

  task automatic step(input bit r, input logic [NUM_CH-1:0] e, input bit v,
                      input int c, input int unsigned d, input bit s);
    bit rdy, xfer, sv;
    logic [NUM_CH-1:0] dc, dt;
    logic [1:0] smp;
    @(negedge clk_in);
    sv = s;
`ifdef CLKDIV_SYNC_EN
    sync_start = sv;
`else
    sv = 1'b0;
`endif
    rst = r; en = e; cfg_valid = v; cfg_ch = CH_AW'(c); cfg_div = WIDTH'(d);
    rdy = !(c < NUM_CH && pm[c]);
    if (known) rdy_q.push_back(rdy);
    dc = '0; dt = '0;
    if (r) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        dact[ch] = sat(DEF); pm[ch] = 1'b0; load(ch, dact[ch]);
      end
      known = 1'b1;
    end else begin
      xfer = v && rdy && (c < NUM_CH);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (!e[ch] || sv || left[ch].size() == 0) begin
          if (pm[ch]) begin dact[ch] = dpend[ch]; pm[ch] = 1'b0; end
          load(ch, dact[ch]);
        end else begin
          smp = left[ch].pop_front();
          dc[ch] = smp[1]; dt[ch] = smp[0];
        end
      end
      if (xfer) begin dpend[c] = sat(d); pm[c] = 1'b1; end
    end
    if (known) out_q.push_back({dc, dt, NUM_CH'(pm)});
  endtask

  task automatic idle(input int n, input logic [NUM_CH-1:0] e);
    for (int k = 0; k < n; k++) step(1'b0, e, 1'b0, 0, 0, 1'b0);
  endtask

  // Output monitor: registered outputs sampled just after the active edge.
  initial begin
    logic [3*NUM_CH-1:0] ex;
    forever begin
      @(posedge clk_in); #1;
      if (out_q.size() > 0) begin
        ex = out_q.pop_front();
        n_cmp++;
        if ({clk_out, tick, pending} !== ex) begin
          n_err++;
          $display("FAIL outputs t=%0t clk_out/tick/pending got %b/%b/%b exp %b/%b/%b", $time,
                   clk_out, tick, pending, ex[3*NUM_CH-1:2*NUM_CH], ex[2*NUM_CH-1:NUM_CH], ex[NUM_CH-1:0]);
        end
      end
    end
  end

  // Handshake monitor: cfg_ready checked once the cycle's inputs have settled.
  initial begin
    logic ex;
    forever begin
      @(negedge clk_in); #1;
      if (rdy_q.size() > 0) begin
        ex = rdy_q.pop_front();
        n_cmp++;
        if (cfg_ready !== ex) begin
          n_err++;
          $display("FAIL cfg_ready t=%0t ch=%0d got %b exp %b", $time, cfg_ch, cfg_ready, ex);
        end
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] e;
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
`ifdef CLKDIV_SYNC_EN
    sync_start = 1'b0;
`endif
    step(1'b1, '0, 1'b0, 0, 0, 1'b0);
    step(1'b1, '0, 1'b0, 0, 0, 1'b0);
    idle(12, 3'b001);                                   // default divisor on ch0
    step(1'b0, 3'b001, 1'b1, 1, 5, 1'b0);               // stage 5 on disabled ch1
    idle(3, 3'b001);
    idle(15, 3'b011);
    step(1'b0, 3'b011, 1'b1, 0, 6, 1'b0);               // ch0 -> 6, then a stalled second write
    for (int k = 0; k < 8; k++) step(1'b0, 3'b011, 1'b1, 0, 7, 1'b0);
    idle(20, 3'b011);
    step(1'b0, 3'b111, 1'b1, 2, 0, 1'b0);               // saturation to 2
    idle(6, 3'b111);
    for (int k = 0; k < 6; k++) step(1'b0, 3'b111, 1'b1, 2, 1, 1'b0);
    idle(6, 3'b111);
    idle(2, 3'b110);                                    // drop and re-enable ch0
    idle(16, 3'b111);
    step(1'b0, 3'b111, 1'b1, 3, 9, 1'b0);               // out-of-range channel is dropped
    step(1'b0, 3'b111, 1'b1, 2, 9, 1'b0);               // leave ch2 pending, then reset
    step(1'b1, 3'b111, 1'b0, 0, 0, 1'b0);
    idle(12, 3'b111);
    step(1'b0, 3'b111, 1'b0, 0, 0, 1'b1);               // global restart (when built in)
    idle(8, 3'b111);
    e = 3'b111;
    for (int k = 0; k < 4000; k++) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        if ($urandom_range(0, 15) == 0) e[ch] = ~e[ch];
      step(1'(($urandom_range(0, 299) == 0)), e, 1'($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 3)), $urandom_range(0, 9), 1'($urandom_range(0, 99) == 0));
    end
    idle(4, e);
    repeat (3) @(posedge clk_in);
    #2;
    n_cmp++;
    if (out_q.size() != 0 || rdy_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d/%0d entries left exp 0/0", out_q.size(), rdy_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Multi-channel, runtime-programmable clock divider and tick generator.
- Replaces fixed-divisor dividers in the design.
- Each channel produces a registered divided clock, clk_out, with near-50% duty, plus a one-cycle period strobe, tick.
- Divisors are loaded per channel over a valid/ready config port. A new divisor takes effect only at a period boundary, so clk_out never has a runt pulse.

Parameters:
- WIDTH, 32: counter and divisor width.
- NUM_CH, 4: number of independent channels.
- CH_AW, 2: width of channel select; 2**CH_AW >= NUM_CH.
- DEFAULT_DIV, 6000000: divisor loaded into every channel at reset. Values < 2 are treated as 2.

Ports:
- clk_in  input  1  single clock domain; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  NUM_CH  per-channel run enable.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accept; combinational, equals NOT pend[cfg_ch].
- cfg_ch  input  CH_AW  target channel.
- cfg_div  input  WIDTH  new divisor, in clk_in cycles per output period.
- clk_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  one-cycle strobe in the last cycle of each period, registered.
- pending  output  NUM_CH  channel has an accepted divisor not yet applied.

Behaviour:
- Reset (rst=1 at a clk_in edge): for every channel:
  - cnt=0, div_act=max(DEFAULT_DIV,2), pend=0.
  - clk_out=0, tick=0, pending=0.
  - cfg_ready=1 for all channels.
- Per-channel state: cnt[WIDTH], div_act[WIDTH], div_pend[WIDTH], pend.
- Running (en[i]=1):
  - cnt increments every cycle.
  - When cnt==div_act-1, cnt wraps to 0 on the next edge.
- Output decode, as seen in a cycle with count value cnt:
  - clk_out = (cnt >= div_act>>1).
  - tick = (cnt == div_act-1).
  - Both are registers computed from the next-state count, so they show no combinational glitches. They are in phase with cnt: after reset with en=1, clk_out is 0 for the first div_act>>1 cycles.
- Duty cycle:
  - Even D: D/2 cycles low, then D/2 cycles high.
  - Odd D: floor(D/2) cycles low, then ceil(D/2) cycles high.
- Divisor saturation: cfg_div of 0 or 1 is stored as 2; the output toggles every clk_in cycle.
- Config handshake:
  - A transfer occurs on an edge with cfg_valid & cfg_ready.
  - On transfer: div_pend[cfg_ch] <= sat(cfg_div), pend[cfg_ch] <= 1.
  - cfg_ch >= NUM_CH: cfg_ready=1 and the write is discarded.
  - Only one pending slot per channel; a second write to a channel with pend=1 stalls (cfg_ready=0) until the pending value is applied.
- Apply, running channel:
  - On the wrap edge (cnt==div_act-1): div_act<=div_pend, pend<=0, cnt<=0.
  - The current period always completes with the old divisor.
  - A write accepted on the same edge as a wrap is not applied at that wrap; it is applied at the next one.
- Disabled (en[i]=0):
  - Next edge: cnt<=0, clk_out<=0, tick<=0.
  - A pending divisor is applied immediately on that edge.
  - Re-asserting en restarts cleanly from cnt=0, phase-aligned.
- Reset mid-operation: discards pending writes; div_act returns to DEFAULT_DIV.
- Channel independence: channels share no state except the config port.
- Width rule: all compares and increments are unsigned, WIDTH bits. DEFAULT_DIV must fit in WIDTH.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - Adds input sync_start (1 bit).
  - When sync_start=1 at an edge (and rst=0), every channel does cnt<=0, clk_out<=0, tick<=0, and applies any pending divisor. This phase-aligns all channels.
  - rst has priority over sync_start.
  - sync_start has priority over a wrap.
- Not defined: the port is absent and there is no global restart.

Test Plan:
- DEFAULT_DIV=4, en[0]=1 after reset → clk_out[0] pattern 0,0,1,1 repeating; tick[0] high in cycles 3, 7, 11.
- Write div=5 to ch1 while en[1]=0, then enable → clk_out[1] low 2, high 3; tick every 5 cycles. Ch0 is unaffected.
- Ch0 at div=4: write 6 when cnt=1 → pending[0]=1 and cfg_ready low for ch0; a second write stalls. The period in progress ends after cycle 3 with the old divisor; subsequent periods are 3 low + 3 high. pending clears at the wrap.
- Write cfg_div=0, then cfg_div=1 → channel toggles every cycle (period 2).
- Drop en[0] at cnt=2 with clk_out=1 → next cycle clk_out=0, tick=0. Re-enable → first tick after div_act cycles.
- rst pulse with a pending write on ch2 → all outputs 0, pending=0. Ch2 runs at DEFAULT_DIV. With CLKDIV_SYNC_EN defined, sync_start re-aligns all channels' tick edges.
